sevenseg_scan_driver: RTL
=========================

// Module: sevenseg_scan_driver
//
// PURPOSE
//   Time-multiplexed driver for an N-digit, common-anode, active-low 7-segment display.
//   - Generalises the fixed 4-digit 1 kHz driver: runs from the system clock with an internal
//     scan prescaler, any digit count, ghosting guard band and PWM brightness.
//   - Sits between display-formatting logic and the board's anode/segment pins.
//
// PARAMETERS
//   NUM_DIGITS   4        digits scanned; >= 2
//   CLK_DIV      100000   clk_i cycles per digit slot; > BLANK_CYCLES
//   BLANK_CYCLES 16       cycles at slot start with all anodes off (ghosting guard)
//   BRIGHT_W     3        brightness code width; 2**BRIGHT_W levels
//
// PORTS
//   clk_i        in   1               system clock
//   rst_i        in   1               synchronous, active-high reset
//   scan_en_i    in   1               0: freeze scan, blank display
//   brightness_i in   BRIGHT_W        0 = dimmest, all-ones = full dwell
//   digit_en_i   in   NUM_DIGITS      per-digit enable; bit k -> digit k
//   digits_i     in   4*NUM_DIGITS    hex nibble k at [4k+3:4k]
//   dp_i         in   NUM_DIGITS      decimal point request (SEVENSEG_DP_EN only)
//   anode_o      out  NUM_DIGITS      active-low digit select
//   segments_o   out  7               active-low {g,f,e,d,c,b,a}
//   dp_o         out  1               active-low decimal point
//
// BEHAVIOUR
//   - Reset: anode_o='1, segments_o='1, dp_o=1, prescaler cnt=0, digit index idx=0.
//     Reset mid-slot takes effect on the next edge.
//   - Prescaler: cnt counts 0..CLK_DIV-1 and wraps while scan_en_i=1.
//     On wrap, idx advances 0..NUM_DIGITS-1 and wraps to 0. Disabled digits are NOT skipped.
//   - Slot sampling: at cnt==0, the following are captured into slot registers.
//     Mid-slot input changes are not visible until the next slot.
//     - brightness_i
//     - digits_i[idx]
//     - digit_en_i[idx]
//     - dp_i[idx]
//   - Timing terms:
//     - dwell  = CLK_DIV-BLANK_CYCLES
//     - on_len = ((bright+1)*dwell) >> BRIGHT_W, with the product width sized to avoid overflow.
//       on_len >= 1 is guaranteed by parameter check.
//   - Digit on: anode bit idx is low iff all of the following hold; all other anode bits stay high:
//     - cnt >= BLANK_CYCLES
//     - cnt - BLANK_CYCLES < on_len
//     - digit enabled
//   - Outputs are registered, one cycle after the cnt value that causes them.
//     Whenever no anode is active, segments_o='1 and dp_o=1.
//     At most one anode bit is low in any cycle.
//   - scan_en_i=0: cnt and idx hold; the next cycle's outputs are blanked.
//     On re-enable, the scan resumes from the held cnt/idx.
//   - Segment encoding, active-low {g..a}:
//     0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000
//     8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110
//
// CONFIGURATION
//   SEVENSEG_DP_EN defined:
//     - dp_o = ~dp slot register whenever the digit is on.
//   SEVENSEG_DP_EN undefined:
//     - dp_i is ignored and its slot register is not built.
//     - dp_o is tied to 1.
//
// STRUCTURE
//   - sevenseg_pkg:
//     - typedef hex_t (logic [3:0]) and seg_t (logic [6:0])
//     - constant SEG_BLANK = 7'h7F
//     - function hex_to_seg(hex_t) returning seg_t
//   - Sub-module sevenseg_hex_decode: combinational hex_t -> seg_t wrapper around hex_to_seg.
//   - Top level: prescaler, index counter, slot registers, on-window compare, output registers.
//
// TESTING  (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=1, BRIGHT_W=2 unless stated)
//   1. Reset: hold rst_i 3 cycles
//      -> anode_o=4'b1111, segments_o=7'h7F, dp_o=1. First low anode is 1110, 2 cycles after release.
//   2. Full scan: all enabled, digits_i=16'hC3A5, brightness 3
//      -> each anode low 7 of 8 cycles, in order 1110,1101,1011,0111,1110.
//      -> Segments 0010010 / 0001000 / 0110000 / 1000110. No cycle with >1 anode low.
//   3. Brightness: brightness 0 -> anode low exactly 1 cycle per slot. Brightness 3 -> 7 cycles.
//      Change mid-slot -> applies from the next slot only.
//   4. Disable: digit_en_i=4'b1011
//      -> slot 2 shows anode_o=1111, segments 7'h7F, for the full 8 cycles. Slot timing unchanged.
//   5. Freeze: scan_en_i=0 for 20 cycles mid-slot of digit 1
//      -> outputs blank. After re-enable, digit 1 completes its remaining cycles, then digit 2.
//   6. DP (with SEVENSEG_DP_EN): dp_i=4'b0100 -> dp_o=0 only while anode_o=1011.
//      Without the macro -> dp_o=1 always.
//   - Every test: random inputs for 1000 cycles, with a per-cycle assertion of one-hot-low-or-all-high anodes.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and the hex-to-segment lookup for the 7-segment scan driver.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package sevenseg_pkg;

    typedef logic [3:0] hex_t;
    typedef logic [6:0] seg_t;

    // All segments off (active-low).
    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low glyphs for 0-9 and A, b, C, d, E, F.
    function automatic seg_t hex_to_seg(input hex_t hex);
        seg_t seg;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Signal bundle between display-formatting logic (master) and the scan
// driver (slave).
//
// Handshake: there is no valid/ready pair. Every master-driven field is a
// level that the driver samples once per digit slot, on the cycle the
// prescaler reads zero; changes made later in a slot become visible in the
// next slot. The driver outputs are registered pin levels that are meaningful
// on every cycle outside reset.
interface sevenseg_scan_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 3
);
    logic                    scan_en_i;
    logic [BRIGHT_W-1:0]     brightness_i;
    logic [NUM_DIGITS-1:0]   digit_en_i;
    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   anode_o;
    logic [6:0]              segments_o;
    logic                    dp_o;

    modport master (
        output scan_en_i, brightness_i, digit_en_i, digits_i, dp_i,
        input  anode_o, segments_o, dp_o
    );

    modport slave (
        input  scan_en_i, brightness_i, digit_en_i, digits_i, dp_i,
        output anode_o, segments_o, dp_o
    );
endinterface

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph.
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  hex_t hex,
    output seg_t seg
);

    // Pure lookup; kept as its own block so it can be swapped for a custom font.
    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode, active-low 7-segment
// display. A prescaler splits time into CLK_DIV-cycle digit slots; each slot
// opens with BLANK_CYCLES of all anodes off (ghosting guard) followed by a
// PWM on-window whose length follows the brightness code.
//
// Build option: define SEVENSEG_DP_EN to drive the decimal point from dp_i;
// without it dp_i is ignored and dp_o stays high.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_W     = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    sevenseg_scan_driver_if.slave  bus
);

    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW    = $clog2(NUM_DIGITS);
    localparam int DWELL = CLK_DIV - BLANK_CYCLES;
    // Wide enough for (2**BRIGHT_W) * DWELL without overflow.
    localparam int PW    = BRIGHT_W + CW + 2;

    // Reject configurations that would leave a zero-length on-window.
    if (NUM_DIGITS < 2 || CLK_DIV <= BLANK_CYCLES || DWELL < (1 << BRIGHT_W)) begin : g_bad_params
        $error("sevenseg_scan_driver: illegal parameter combination");
    end

    logic [CW-1:0]       cnt_q;
    logic [IW-1:0]       idx_q;
    logic [BRIGHT_W-1:0] bright_q;
    hex_t                digit_q;
    logic                en_q;

    logic                slot_start;
    logic [BRIGHT_W-1:0] bright_eff;
    hex_t                digit_eff;
    logic                en_eff;
    logic [IW+1:0]       nib_base;
    logic [PW-1:0]       on_prod;
    logic [PW-1:0]       on_len;
    logic [PW-1:0]       cnt_ext;
    logic                in_window;
    logic                digit_on;
    seg_t                seg_dec;

    logic [NUM_DIGITS-1:0] anode_d, anode_q;
    seg_t                  seg_d, seg_q;

    assign slot_start = (cnt_q == '0);
    assign nib_base   = {idx_q, 2'b00};

    // On the capture cycle itself the slot registers are not loaded yet, so
    // the live inputs stand in for them (matters only when BLANK_CYCLES is 0).
    assign bright_eff = slot_start ? bus.brightness_i            : bright_q;
    assign digit_eff  = slot_start ? bus.digits_i[nib_base +: 4] : digit_q;
    assign en_eff     = slot_start ? bus.digit_en_i[idx_q]       : en_q;

    assign on_prod   = (PW'(bright_eff) + PW'(1)) * PW'(DWELL);
    assign on_len    = on_prod >> BRIGHT_W;
    assign cnt_ext   = PW'(cnt_q);
    assign in_window = (cnt_ext >= PW'(BLANK_CYCLES))
                    && ((cnt_ext - PW'(BLANK_CYCLES)) < on_len);
    assign digit_on  = bus.scan_en_i && in_window && en_eff;

    sevenseg_hex_decode u_hex_decode (
        .hex (digit_eff),
        .seg (seg_dec)
    );

    // Prescaler and digit index; both freeze while scanning is disabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (bus.scan_en_i) begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Slot registers: snapshot of the current digit's inputs at slot start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bright_q <= '0;
            digit_q  <= '0;
            en_q     <= 1'b0;
        end else if (bus.scan_en_i && slot_start) begin
            bright_q <= bus.brightness_i;
            digit_q  <= bus.digits_i[nib_base +: 4];
            en_q     <= bus.digit_en_i[idx_q];
        end
    end

    // Next pin levels: everything blank unless the current digit is in its on-window.
    always_comb begin
        anode_d = '1;
        seg_d   = SEG_BLANK;
        if (digit_on) begin
            anode_d[idx_q] = 1'b0;
            seg_d          = seg_dec;
        end
    end

    // Registered anode and segment pins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.anode_o    = anode_q;
    assign bus.segments_o = seg_q;

`ifdef SEVENSEG_DP_EN
    logic dp_slot_q;
    logic dp_eff;
    logic dp_q;

    assign dp_eff = slot_start ? bus.dp_i[idx_q] : dp_slot_q;

    // Decimal-point request captured alongside the other slot registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dp_slot_q <= 1'b0;
        end else if (bus.scan_en_i && slot_start) begin
            dp_slot_q <= bus.dp_i[idx_q];
        end
    end

    // Decimal-point pin follows the same on-window as the anode.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dp_q <= 1'b1;
        end else begin
            dp_q <= digit_on ? ~dp_eff : 1'b1;
        end
    end

    assign bus.dp_o = dp_q;
`else
    logic unused_dp;
    assign unused_dp  = ^bus.dp_i;
    assign bus.dp_o   = 1'b1;
`endif

endmodule
